// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register target.
// State encoding, bus ACK levels and the default device address.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ACK_A,
    RX_PTR,
    ACK_P,
    RX_DATA,
    ACK_D,
    TX,
    TX_ACK,
    IGNORE
  } state_e;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  localparam logic [6:0] I2C_DEV_ADDR = 7'h69;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronises scl/sda into clk and flags bus edges,
// START (sda fall, scl high) and STOP (sda rise, scl high).
module i2c_bus_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic scl,
  input  logic sda,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [1:0] scl_ff;
  logic [1:0] sda_ff;
  logic       scl_d;
  logic       sda_d;
  logic       scl_s;

  // Idle bus is high; reset to 1 so no event fires on release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_ff <= 2'b11;
      sda_ff <= 2'b11;
      scl_d  <= 1'b1;
      sda_d  <= 1'b1;
    end else begin
      scl_ff <= {scl_ff[0], scl};
      sda_ff <= {sda_ff[0], sda};
      scl_d  <= scl_ff[1];
      sda_d  <= sda_ff[1];
    end
  end

  assign scl_s     = scl_ff[1];
  assign sda_s     = sda_ff[1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

endmodule

// File: rtl/i2c_slave_regs.sv
// I2C target with a pointer-addressed register file,
// a write mirror strobe and a combinational host read port.
module i2c_slave_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = I2C_DEV_ADDR,
  parameter int NREG = 16,
  parameter int PW = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          scl,
  input  logic          sda_i,
  output logic          sda_oe,
  output logic          wr_stb,
  output logic [PW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic          busy,
  input  logic [PW-1:0] host_addr,
  output logic [7:0]    host_data
);

  logic sda_s, scl_rise, scl_fall;
  logic start_det, stop_det;

  i2c_bus_sync u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl       (scl),
    .sda       (sda_i),
    .sda_s     (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  state_e        state_q, state_d;
  logic [3:0]    cnt;
  logic [7:0]    sh;
  logic [PW-1:0] ptr;
  logic [7:0]    regs [NREG];
  logic          sda_oe_d;
  logic [7:0]    byte_in, tx_byte;
  logic          ev, byte_end, ack_end;
  logic          addr_hit, rw, reg_we;

  assign ev        = start_det | stop_det;
  assign byte_in   = {sh[6:0], sda_s};
  assign byte_end  = scl_rise && (cnt == 4'd7);
  assign ack_end   = scl_fall && sda_oe;
  assign addr_hit  = byte_in[7:1] == DEV_ADDR;
  assign rw        = sh[0];
  assign tx_byte   = regs[ptr];
  assign host_data = regs[host_addr];
  assign reg_we    = !ev && state_q == RX_DATA
                     && byte_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (stop_det) begin
      state_d = IDLE;
    end else if (start_det) begin
      state_d = ADDR;
    end else begin
      unique case (state_q)
        ADDR:
          if (byte_end)
            state_d = addr_hit ? ACK_A : IGNORE;
        ACK_A:
          if (ack_end) state_d = rw ? TX : RX_PTR;
        RX_PTR:
          if (byte_end) state_d = ACK_P;
        ACK_P, ACK_D:
          if (ack_end) state_d = RX_DATA;
        RX_DATA:
          if (byte_end) state_d = ACK_D;
        TX:
          if (scl_fall && cnt == 4'd8)
            state_d = TX_ACK;
        TX_ACK:
          if (scl_rise && sda_s == I2C_NACK)
            state_d = IGNORE;
          else if (scl_fall)
            state_d = TX;
        default: ;
      endcase
    end
  end

  // ACK states: first fall pulls SDA, second releases
  // (or presents the first read bit when entering TX).
  always_comb begin
    sda_oe_d = sda_oe;
    if (ev) begin
      sda_oe_d = 1'b0;
    end else begin
      unique case (state_q)
        ACK_A, ACK_P, ACK_D:
          if (scl_fall) begin
            if (!sda_oe)
              sda_oe_d = 1'b1;
            else if (state_q == ACK_A && rw)
              sda_oe_d = ~tx_byte[7];
            else
              sda_oe_d = 1'b0;
          end
        TX:
          if (scl_fall)
            sda_oe_d = (cnt == 4'd8) ? 1'b0 : ~sh[7];
        TX_ACK:
          if (scl_fall) sda_oe_d = ~tx_byte[7];
        IDLE, IGNORE:
          sda_oe_d = 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      sh      <= '0;
      ptr     <= '0;
      busy    <= 1'b0;
      sda_oe  <= 1'b0;
      wr_stb  <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      sda_oe <= sda_oe_d;
      wr_stb <= 1'b0;
      if (ev) begin
        cnt  <= '0;
        busy <= 1'b0;
      end else begin
        unique case (state_q)
          ADDR, RX_PTR, RX_DATA:
            if (scl_rise) begin
              sh  <= byte_in;
              cnt <= byte_end ? 4'd0 : cnt + 4'd1;
              if (byte_end && state_q == ADDR)
                busy <= addr_hit;
              if (byte_end && state_q == RX_PTR)
                ptr <= byte_in[PW-1:0];
              if (reg_we) begin
                wr_stb  <= 1'b1;
                wr_addr <= ptr;
                wr_data <= byte_in;
                ptr     <= ptr + PW'(1);
              end
            end
          ACK_A:
            if (ack_end && rw) begin
              sh  <= {tx_byte[6:0], 1'b0};
              cnt <= 4'd1;
            end
          TX:
            if (scl_fall && cnt != 4'd8) begin
              sh  <= {sh[6:0], 1'b0};
              cnt <= cnt + 4'd1;
            end
          TX_ACK: begin
            if (scl_rise && sda_s == I2C_ACK)
              ptr <= ptr + PW'(1);
            if (scl_fall) begin
              sh  <= {tx_byte[6:0], 1'b0};
              cnt <= 4'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++)
        regs[i] <= '0;
    end else if (reg_we) begin
      regs[ptr] <= byte_in;
    end
  end

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Bench for i2c_slave_regs: bit-banged master on a wired-AND bus,
// write scoreboard, vector table plus multi-cycle corner sequences.
module tb_i2c_slave_regs;

  localparam int Q = 5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       scl;
  logic       sda_m;
  logic       sda_i;
  logic       sda_oe;
  logic       wr_stb;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic [3:0] host_addr;
  logic [7:0] host_data;

  assign sda_i = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_slave_regs dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl       (scl),
    .sda_i     (sda_i),
    .sda_oe    (sda_oe),
    .wr_stb    (wr_stb),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .host_addr (host_addr),
    .host_data (host_data)
  );

  typedef struct {
    logic [3:0] a;
    logic [7:0] d;
  } wr_t;

  typedef struct {
    logic [7:0] ptr_b;
    logic [7:0] data;
    logic [3:0] exp_a;
  } vec_t;

  int  n_vec = 0;
  int  n_err = 0;
  wr_t exp_q[$];
  wr_t sb_e;
  logic mon_en = 1'b0;
  logic oe_seen = 1'b0;

  task automatic chk(input string nm,
                     input logic [7:0] act,
                     input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h",
               nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && wr_stb) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL wr_unexp: got %h/%h, required none",
                 wr_addr, wr_data);
      end else begin
        sb_e = exp_q.pop_front();
        if (wr_addr !== sb_e.a || wr_data !== sb_e.d) begin
          n_err++;
          $display("FAIL wr_evt: got %h/%h, required %h/%h",
                   wr_addr, wr_data, sb_e.a, sb_e.d);
        end
      end
    end
    if (mon_en && sda_oe) oe_seen = 1'b1;
  end

  task automatic clk_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, output logic s);
    sda_m = b;
    clk_n(Q);
    scl = 1'b1;
    clk_n(Q);
    s = sda_i;
    clk_n(Q);
    scl = 1'b0;
    clk_n(Q);
  endtask

  task automatic bus_start();
    sda_m = 1'b1;
    clk_n(Q);
    scl = 1'b1;
    clk_n(Q);
    sda_m = 1'b0;
    clk_n(Q);
    scl = 1'b0;
    clk_n(Q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0;
    clk_n(Q);
    scl = 1'b1;
    clk_n(Q);
    sda_m = 1'b1;
    clk_n(2 * Q);
  endtask

  task automatic write_byte(input logic [7:0] b,
                            output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) send_bit(b[i], s);
    send_bit(1'b1, ack);
  endtask

  task automatic read_byte(output logic [7:0] d,
                           input logic m_ack);
    logic s;
    for (int i = 7; i >= 0; i--) send_bit(1'b1, d[i]);
    send_bit(m_ack, s);
  endtask

  task automatic wr1(input logic [7:0] p,
                     input logic [7:0] d);
    logic ack;
    bus_start();
    write_byte(8'hD2, ack);
    chk("ack_addr", {7'd0, ack}, 8'd0);
    chk("busy_on", {7'd0, busy}, 8'd1);
    write_byte(p, ack);
    chk("ack_ptr", {7'd0, ack}, 8'd0);
    exp_q.push_back('{p[3:0], d});
    write_byte(d, ack);
    chk("ack_data", {7'd0, ack}, 8'd0);
    bus_stop();
    chk("busy_off", {7'd0, busy}, 8'd0);
  endtask

  vec_t       vt[5];
  logic       ack;
  logic       s;
  logic [7:0] rd;

  initial begin
    vt[0] = '{8'h25, 8'h14, 4'd5};
    vt[1] = '{8'h03, 8'h5A, 4'd3};
    vt[2] = '{8'hF7, 8'hC3, 4'd7};
    vt[3] = '{8'h00, 8'h01, 4'd0};
    vt[4] = '{8'h3E, 8'h80, 4'd14};

    rst_n = 1'b0;
    scl = 1'b1;
    sda_m = 1'b1;
    host_addr = 4'd0;
    clk_n(4);
    rst_n = 1'b1;
    clk_n(4);
    chk("rst_oe", {7'd0, sda_oe}, 8'd0);
    chk("rst_stb", {7'd0, wr_stb}, 8'd0);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_host", host_data, 8'd0);

    for (int i = 0; i < 5; i++) begin
      wr1(vt[i].ptr_b, vt[i].data);
      host_addr = vt[i].exp_a;
      #1;
      chk("host_rd", host_data, vt[i].data);
    end

    // pointer write, repeated START, read two bytes
    bus_start();
    write_byte(8'hD2, ack);
    write_byte(8'h05, ack);
    chk("ack_rp", {7'd0, ack}, 8'd0);
    bus_start();
    write_byte(8'hD3, ack);
    chk("ack_rd", {7'd0, ack}, 8'd0);
    read_byte(rd, 1'b0);
    chk("rd0", rd, 8'h14);
    read_byte(rd, 1'b1);
    chk("rd1", rd, 8'h00);
    clk_n(Q);
    chk("rel_nack", {7'd0, sda_oe}, 8'd0);
    bus_stop();

    // foreign address
    mon_en = 1'b1;
    bus_start();
    write_byte(8'hA0, ack);
    chk("nack_addr", {7'd0, ack}, 8'd1);
    chk("busy_foreign", {7'd0, busy}, 8'd0);
    write_byte(8'h01, ack);
    bus_stop();
    mon_en = 1'b0;
    chk("no_oe", {7'd0, oe_seen}, 8'd0);

    // pointer wrap
    bus_start();
    write_byte(8'hD2, ack);
    write_byte(8'h0F, ack);
    exp_q.push_back('{4'hF, 8'hAA});
    write_byte(8'hAA, ack);
    exp_q.push_back('{4'h0, 8'hBB});
    write_byte(8'hBB, ack);
    chk("ack_wrap", {7'd0, ack}, 8'd0);
    bus_stop();
    host_addr = 4'hF;
    #1;
    chk("wrap_f", host_data, 8'hAA);
    host_addr = 4'h0;
    #1;
    chk("wrap_0", host_data, 8'hBB);

    // STOP after 4 data bits
    bus_start();
    write_byte(8'hD2, ack);
    write_byte(8'h02, ack);
    send_bit(1'b1, s);
    send_bit(1'b0, s);
    send_bit(1'b1, s);
    send_bit(1'b1, s);
    bus_stop();
    chk("abort_busy", {7'd0, busy}, 8'd0);
    host_addr = 4'h2;
    #1;
    chk("abort_reg", host_data, 8'h00);
    wr1(8'h02, 8'h77);
    #1;
    chk("post_abort", host_data, 8'h77);

    // read with the persisted pointer (now 3)
    bus_start();
    write_byte(8'hD3, ack);
    read_byte(rd, 1'b1);
    chk("rd_persist", rd, 8'h5A);
    bus_stop();
    chk("sb_empty", 8'(exp_q.size()), 8'd0);

    // reset while the slave is pulling SDA for the ACK
    bus_start();
    for (int i = 7; i >= 0; i--) begin
      rd = 8'hD2;
      send_bit(rd[i], s);
    end
    sda_m = 1'b1;
    clk_n(Q);
    chk("ack_drv", {7'd0, sda_oe}, 8'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_rel", {7'd0, sda_oe}, 8'd0);
    chk("rst_busy2", {7'd0, busy}, 8'd0);
    chk("rst_waddr", {4'd0, wr_addr}, 8'd0);
    chk("rst_wdata", wr_data, 8'd0);
    for (int i = 0; i < 16; i++) begin
      host_addr = 4'(i);
      #1;
      chk("rst_reg", host_data, 8'd0);
    end
    scl = 1'b1;
    clk_n(4);
    rst_n = 1'b1;
    clk_n(4);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
